uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter: the transmit counterpart of the UART receiver in the same oversampled-clock domain. It accepts a parallel byte through a valid/busy handshake and serialises it on TX_OUT, LSB first, as start bit, 8 data bits, an optional parity bit and a stop bit. Each bit is held for Prescale clock cycles, so transmitter and receiver share one clock and one Prescale setting.

## Interface
Parameters:
- PRESCALE_WIDTH, 6: width of Prescale and of the internal edge counter (covers up to 32).
- DATA_WIDTH, 8: payload bits per frame.

Ports:
- CLK  input  1  oversampling clock, the same as the receiver's.
- RST  input  1  reset, asynchronous, active-low.
- P_DATA  input  DATA_WIDTH  byte to send; sampled on acceptance only.
- Data_Valid  input  1  transmit request.
- Prescale  input  PRESCALE_WIDTH  clock cycles per bit.
- PAR_EN  input  1  parity bit enable (present only with UART_TX_PARITY_EN).
- PAR_TYP  input  1  0 = even, 1 = odd (present only with UART_TX_PARITY_EN).
- TX_OUT  output  1  serial line, registered, idles high.
- busy  output  1  frame in progress, registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1 and busy=0.
  - Data_Valid=1 sampled in IDLE means the request is accepted.
  - On acceptance the block latches P_DATA, Prescale, PAR_EN and PAR_TYP, then goes to START.
- Data_Valid while busy=1 is ignored; there is no queueing.
- START: TX_OUT=0 for Prescale cycles, then go to DATA.
- DATA: bit i (i=0..DATA_WIDTH-1, LSB first) is driven for Prescale cycles.
  - After the last bit, go to PARITY if the latched PAR_EN=1, else to STOP.
- PARITY: TX_OUT = ^data (even) or ~^data (odd) of the latched byte, for Prescale cycles.
- STOP: TX_OUT=1 for Prescale cycles, then return to IDLE.
- Edge counter counts 0..Prescale-1 within a bit; on reaching Prescale-1 it wraps to 0 and advances the bit counter.
  - Both counters are cleared whenever the FSM is in IDLE.
- Latched Prescale values 0 and 1 behave as 2.
- Changes to Prescale, P_DATA or PAR_* mid-frame have no effect until the next acceptance.
- Reset (any time, including mid-frame): state=IDLE, TX_OUT=1, busy=0, counters=0, latched data=0.
  - Takes effect asynchronously; no partial frame resumes after reset release.

## Timing
- Acceptance in cycle k: at edge k+1, TX_OUT=0 and busy=1 (one-cycle latency).
- Frame length is N×Prescale cycles: N=10 without parity, N=11 with parity.
- busy is high for exactly that many cycles.
- After the final stop cycle, the FSM is in IDLE with busy=0 for at least one cycle.
- With Data_Valid held high continuously, consecutive start bits are separated by the stop bit plus exactly one idle cycle (Prescale+1 high cycles).
- TX_OUT is glitch-free: driven directly from a flop.

## Configuration
- UART_TX_PARITY_EN defined:
  - PAR_EN and PAR_TYP ports exist.
  - The PARITY state and parity logic are compiled in.
- Not defined:
  - Ports are absent and the PARITY state is removed.
  - Frames are always 10 bits (8N1).

## Structure
- Shared package uart_pkg holds:
  - the TX state enum (IDLE, START, DATA, PARITY, STOP);
  - parity-type constants PAR_EVEN=0 and PAR_ODD=1;
  - frame-length constants.
- One natural sub-module, uart_tx_baud_counter, holds the edge counter and bit counter.
  - Inputs: enable, latched Prescale.
  - Outputs: bit_done, bit_cnt.
- FSM and output mux stay in uart_tx.

## Test plan
- Prescale=8, no parity, send 0xA5:
  - Expect TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles.
  - busy high for 80 cycles; TX_OUT high afterwards.
- Prescale=16, PAR_EN=1, send 0x07:
  - PAR_TYP=0 gives parity bit 1; PAR_TYP=1 gives parity bit 0.
  - Frame length 176 cycles.
- Data_Valid pulsed with 0xFF mid-frame of 0x3C:
  - The 0x3C frame is unchanged and no second frame follows.
- RST asserted during data bit 3:
  - TX_OUT=1 and busy=0 immediately.
  - After release, sending 0x55 produces a correct full frame.
- Data_Valid held high, Prescale=8, P_DATA toggling 0x00/0xFF:
  - Back-to-back frames, each with 9 high cycles between stop start and next start bit.
  - Each frame carries the byte latched at its acceptance.
- Prescale changed from 8 to 32 mid-frame:
  - The current frame keeps 8-cycle bits; the next frame uses 32-cycle bits.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter types and constants.
// UART_TX_PARITY_EN adds the PARITY state to the TX state enum.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } tx_state_e;
`endif

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int FRAME_BITS_NOPAR = 10;
  localparam int FRAME_BITS_PAR   = 11;

endpackage

// File: rtl/uart_tx_baud_counter.sv
// rtl/uart_tx_baud_counter.sv - per-bit edge counter and frame bit counter for uart_tx.
// Both counters hold at zero while enable_i is low.
module uart_tx_baud_counter #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      bit_done_o,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt_o
);

  logic [PRESCALE_WIDTH-1:0] cyc_q, cyc_d;
  logic [BIT_CNT_WIDTH-1:0]  bit_q, bit_d;
  logic                      done;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cyc_q <= '0;
      bit_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      bit_q <= bit_d;
    end
  end

  always_comb begin
    cyc_d = '0;
    bit_d = '0;
    done  = 1'b0;
    if (enable_i) begin
      done = (cyc_q == prescale_i - PRESCALE_WIDTH'(1));
      if (done) begin
        cyc_d = '0;
        bit_d = bit_q + BIT_CNT_WIDTH'(1);
      end else begin
        cyc_d = cyc_q + PRESCALE_WIDTH'(1);
        bit_d = bit_q;
      end
    end
  end

  assign bit_done_o = done;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, stop.
// UART_TX_PARITY_EN enables the PAR_EN/PAR_TYP ports and the parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
`ifdef UART_TX_PARITY_EN
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
`endif
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int BCW = $clog2(DATA_WIDTH + 4);
  localparam logic [PRESCALE_WIDTH-1:0] PS_MIN = PRESCALE_WIDTH'(2);

  tx_state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [DATA_WIDTH-1:0]     data_mask;
  logic [PRESCALE_WIDTH-1:0] ps_q, ps_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      baud_en;
  logic                      bit_done;
  logic                      data_bit;
  logic [BCW-1:0]            bit_cnt, bit_cnt_nx;
`ifdef UART_TX_PARITY_EN
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      par_bit;
`endif

  assign baud_en = (state_q != IDLE);

  uart_tx_baud_counter #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH),
    .BIT_CNT_WIDTH (BCW)
  ) u_baud (
    .CLK       (CLK),
    .RST       (RST),
    .enable_i  (baud_en),
    .prescale_i(ps_q),
    .bit_done_o(bit_done),
    .bit_cnt_o (bit_cnt)
  );

`ifdef UART_TX_PARITY_EN
  assign par_bit = (par_typ_q == PAR_ODD) ? ~^data_q : ^data_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      ps_q      <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      ps_q      <= ps_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
`endif
    end
  end

  // Outputs are decoded from the next state so TX_OUT and busy come straight from flops.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    ps_d       = ps_q;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
`endif
    tx_d       = 1'b1;
    busy_d     = 1'b1;
    bit_cnt_nx = bit_cnt + BCW'(bit_done);
    data_mask  = DATA_WIDTH'(1) << (bit_cnt_nx - BCW'(1));
    data_bit   = |(data_q & data_mask);

    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          state_d   = START;
          data_d    = P_DATA;
          ps_d      = (Prescale < PS_MIN) ? PS_MIN : Prescale;
`ifdef UART_TX_PARITY_EN
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
`endif
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done && (bit_cnt == BCW'(DATA_WIDTH))) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      START:  tx_d = 1'b0;
      DATA:   tx_d = data_bit;
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_bit;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx; parity vectors run when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Data_Valid = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic [5:0] Prescale = 6'd8;
`ifdef UART_TX_PARITY_EN
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
`endif
  logic       TX_OUT;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    int         ps;
    bit         par_en;
    bit         par_typ;
    bit         par_bit;
    bit         b2b;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_busy = 1'b0;

  uart_tx dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .Prescale  (Prescale),
`ifdef UART_TX_PARITY_EN
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
`endif
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Walks one frame cycle by cycle; the start cycle has already been sampled by the caller.
  task automatic run_frame(input exp_t it, output bit aborted);
    int nb;
    aborted = 1'b0;
    nb = it.par_en ? 11 : 10;
    for (int b = 0; b < nb; b++) begin
      logic       expb;
      logic [7:0] sh;
      logic [1:0] seen;
      sh = it.data >> (b - 1);
      if (b == 0) expb = 1'b0;
      else if (b <= 8) expb = sh[0];
      else if (it.par_en && b == 9) expb = it.par_bit;
      else expb = 1'b1;
      seen = {1'b1, expb};
      for (int c = 0; c < it.ps; c++) begin
        if (b != 0 || c != 0) begin
          @(posedge CLK);
          #1;
        end
        if (!RST) begin
          aborted = 1'b1;
          return;
        end
        if ({busy, TX_OUT} !== {1'b1, expb} && seen === {1'b1, expb}) seen = {busy, TX_OUT};
      end
      chk($sformatf("frame_%02h_ps%0d_pt%0d_bit%0d", it.data, it.ps, it.par_typ, b),
          int'(seen), int'({1'b1, expb}));
    end
  endtask

  initial begin : monitor
    exp_t it;
    bit   aborted;
    bit   have_start;
    int   n;
    have_start = 1'b0;
    forever begin
      if (!have_start) begin
        @(posedge CLK);
        #1;
      end
      have_start = 1'b0;
      if (RST && TX_OUT === 1'b0) begin
        chk("frame_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          it = sb.pop_front();
          mon_busy = 1'b1;
          run_frame(it, aborted);
          if (!aborted) begin
            @(posedge CLK);
            #1;
            chk("idle_after_frame", int'({busy, TX_OUT}), 1);
            if (it.b2b) begin
              @(posedge CLK);
              #1;
              chk("b2b_next_start", int'(TX_OUT), 0);
              have_start = (TX_OUT === 1'b0);
            end
          end
          mon_busy = 1'b0;
        end else begin
          n = 0;
          while (busy === 1'b1 && n < 2000) begin
            @(posedge CLK);
            n++;
          end
          #1;
        end
      end
    end
  end

  task automatic wait_not_busy();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_wait", int'(busy), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || mon_busy || busy) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk("frame_drain", int'(n < 3000), 1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] d, input int ps_in, input int ps_exp,
                      input bit pen, input bit ptyp, input bit pbit);
    exp_t it;
    wait_not_busy();
    P_DATA     = d;
    Prescale   = 6'(ps_in);
`ifdef UART_TX_PARITY_EN
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
`endif
    Data_Valid = 1'b1;
    it = '{data: d, ps: ps_exp, par_en: pen, par_typ: ptyp, par_bit: pbit, b2b: 1'b0};
    sb.push_back(it);
    @(negedge CLK);
    Data_Valid = 1'b0;
    P_DATA     = ~d;
  endtask

  initial begin : driver
    exp_t it;
    repeat (3) @(negedge CLK);
    chk("reset_tx", int'(TX_OUT), 1);
    chk("reset_busy", int'(busy), 0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_reset_idle", int'({busy, TX_OUT}), 1);

    send(8'hA5, 8, 8, 1'b0, 1'b0, 1'b0);
    wait_done();

    // Request mid-frame must be dropped, not queued.
    send(8'h3C, 8, 8, 1'b0, 1'b0, 1'b0);
    repeat (30) @(negedge CLK);
    P_DATA     = 8'hFF;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    wait_done();
    repeat (40) @(negedge CLK);
    chk("no_second_frame", int'(busy), 0);

    // Reset during data bit 3 (cycles 32..39 after the start edge).
    send(8'h00, 8, 8, 1'b0, 1'b0, 1'b0);
    repeat (35) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_mid_tx", int'(TX_OUT), 1);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("after_rst_idle", int'({busy, TX_OUT}), 1);
    send(8'h55, 8, 8, 1'b0, 1'b0, 1'b0);
    wait_done();

    // Data_Valid held high: back-to-back frames with alternating payloads.
    Prescale = 6'd8;
    for (int f = 0; f < 4; f++) begin
      wait_not_busy();
      P_DATA     = (f % 2 == 1) ? 8'hFF : 8'h00;
      Data_Valid = 1'b1;
      it = '{data: P_DATA, ps: 8, par_en: 1'b0, par_typ: 1'b0, par_bit: 1'b0, b2b: (f < 3)};
      sb.push_back(it);
      @(negedge CLK);
      P_DATA = ~P_DATA;
      if (f == 3) Data_Valid = 1'b0;
    end
    wait_done();

    // Prescale change mid-frame only affects the next frame.
    send(8'h96, 8, 8, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge CLK);
    Prescale = 6'd32;
    wait_done();
    send(8'h69, 32, 32, 1'b0, 1'b0, 1'b0);
    wait_done();

    // Prescale 1 and 0 behave as 2.
    send(8'hC3, 1, 2, 1'b0, 1'b0, 1'b0);
    wait_done();
    send(8'h3A, 0, 2, 1'b0, 1'b0, 1'b0);
    wait_done();

`ifdef UART_TX_PARITY_EN
    send(8'h07, 16, 16, 1'b1, 1'b0, 1'b1);
    wait_done();
    send(8'h07, 16, 16, 1'b1, 1'b1, 1'b0);
    wait_done();
    send(8'hA5, 8, 8, 1'b0, 1'b1, 1'b0);
    wait_done();
`endif

    repeat (5) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
